// File: rtl/cpu4_pkg.sv
// cpu4_pkg
// Shared definitions for the 4-bit CPU front end: instruction opcodes,
// the bubble value placed on the instruction bus when nothing is valid,
// and the fetch FSM state encoding. Also used by alu_ctrl.
// No ports.
package cpu4_pkg;

    localparam logic [3:0] CPU4_JMP_OP = 4'b1111;  // unconditional jump
    localparam logic [3:0] CPU4_JNC_OP = 4'b1110;  // jump if carry clear
    localparam logic [7:0] CPU4_BUBBLE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch
// Instruction fetch stage: issues back-to-back ROM reads, presents each
// fetched byte on D_BUS for exactly one cycle and redirects the program
// counter on taken JMP / JNC instructions.
//
// Ports
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous, active-high
//   rom_req   out  1  fetch request to program ROM
//   rom_addr  out  4  fetch address, stable while rom_req is high
//   rom_ack   in   1  one-cycle acknowledge, rom_data valid same cycle
//   rom_data  in   8  fetched instruction byte
//   cflag     in   1  carry flag, sampled while d_valid is high
//   D_BUS     out  8  instruction register ([7:4] opcode, [3:0] immediate)
//   d_valid   out  1  D_BUS holds a real instruction this cycle
//   br_taken  out  1  jump on D_BUS is taken this cycle
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | single cycle after reset release, no request issued
// FETCH | request on fa outstanding, accepted bytes go to the IR
// FLUSH | branch redirected pc while old request was pending; the byte
//       | returned for that request is dropped, then fetch resumes at pc
module inst_fetch
    import cpu4_pkg::*;
#(
    parameter logic [3:0] JMP_OP = CPU4_JMP_OP,
    parameter logic [3:0] JNC_OP = CPU4_JNC_OP,
    parameter logic [7:0] BUBBLE = CPU4_BUBBLE
) (
    input  logic       clock,
    input  logic       reset,
    output logic       rom_req,
    output logic [3:0] rom_addr,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    input  logic       cflag,
    output logic [7:0] D_BUS,
    output logic       d_valid,
    output logic       br_taken
);

    fetch_state_t state, state_nx;
    logic [3:0]   pc, pc_nx;
    logic [3:0]   fa, fa_nx;
    logic [7:0]   ir, ir_nx;
    logic         valid, valid_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= 4'h0;
            fa    <= 4'h0;
            ir    <= BUBBLE;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            fa    <= fa_nx;
            ir    <= ir_nx;
            valid <= valid_nx;
        end
    end

    // valid is only ever set out of FETCH, so a taken branch can only be
    // seen while in FETCH.
    assign br_taken = valid &&
                      ((ir[7:4] == JMP_OP) || ((ir[7:4] == JNC_OP) && !cflag));

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        fa_nx    = fa;
        // Every instruction is shown for one cycle only; bubble unless a
        // new byte is accepted below.
        ir_nx    = BUBBLE;
        valid_nx = 1'b0;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                fa_nx    = pc;
            end
            FETCH: begin
                if (br_taken) begin
                    pc_nx = ir[3:0];
                    if (rom_ack) begin
                        // byte just returned belongs to the wrong path
                        fa_nx = ir[3:0];
                    end else begin
                        // request on the old fa must still complete
                        state_nx = FLUSH;
                    end
                end else if (rom_ack) begin
                    ir_nx    = rom_data;
                    valid_nx = 1'b1;
                    pc_nx    = pc + 4'd1;
                    fa_nx    = pc + 4'd1;
                end
            end
            FLUSH: begin
                if (rom_ack) begin
                    fa_nx    = pc;
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rom_req  = (state == FETCH) || (state == FLUSH);
    assign rom_addr = fa;
    assign D_BUS    = ir;
    assign d_valid  = valid;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters SHALL be: JMP_OP, 4'b1111, unconditional jump opcode; JNC_OP, 4'b1110, jump-if-no-carry opcode; BUBBLE, 8'h00, D_BUS value when no valid instruction.
REQ-002 Ports SHALL be: clock  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 rom_req  out  1  fetch request to program ROM.
REQ-005 rom_addr  out  4  fetch address, stable while rom_req high.
REQ-006 rom_ack  in  1  one-cycle acknowledge; rom_data valid same cycle.
REQ-007 rom_data  in  8  fetched instruction byte.
REQ-008 cflag  in  1  carry flag from datapath, sampled while d_valid high.
REQ-009 D_BUS  out  8  instruction register to execute stage ([7:4] opcode, [3:0] immediate).
REQ-010 d_valid  out  1  D_BUS holds a real instruction this cycle.
REQ-011 br_taken  out  1  one-cycle pulse: jump in D_BUS taken this cycle.

Function
REQ-012 Block SHALL hold pc (4 bit, next fetch address), fa (4 bit, outstanding address), IR (8 bit), valid bit, 3-state FSM IDLE/FETCH/FLUSH.
REQ-013 IDLE SHALL last one cycle after reset release, then move to FETCH with rom_req=1, fa=pc.
REQ-014 In FETCH, rom_req SHALL stay high and rom_addr=fa SHALL not change until rom_ack.
REQ-015 On rom_ack in FETCH with no taken branch: IR<=rom_data, d_valid<=1 next cycle, pc<=pc+1, fa<=pc+1, rom_req stays high (back-to-back fetch, 1 instr/cycle).
REQ-016 Cycle without rom_ack and no new instruction: IR<=BUBBLE, d_valid<=0 (every instruction presented exactly one cycle).
REQ-017 pc/fa increment SHALL wrap 4'hF -> 4'h0.
REQ-018 Taken branch: d_valid=1 and (IR[7:4]==JMP_OP, or IR[7:4]==JNC_OP and cflag==0); br_taken=1 combinationally that cycle.
REQ-019 Taken branch with rom_ack same cycle: fetched byte SHALL be discarded (IR<=BUBBLE, d_valid<=0), pc<=IR[3:0], fa<=IR[3:0], stay FETCH.
REQ-020 Taken branch without rom_ack: pc<=IR[3:0], fa unchanged, enter FLUSH; rom_req held high on old fa.
REQ-021 FLUSH: on rom_ack data SHALL be discarded, fa<=pc, return to FETCH; d_valid=0 throughout FLUSH.
REQ-022 JNC with cflag==1 or any other opcode SHALL not affect pc; fetch continues sequentially.
REQ-023 Jump target equal to current pc SHALL behave identically to any other target (refetch).
REQ-024 D_BUS SHALL equal BUBBLE whenever d_valid==0.

Reset
REQ-025 reset high SHALL immediately force: pc=0, fa=0, IR=BUBBLE, d_valid=0, br_taken=0, rom_req=0, state IDLE.
REQ-026 Reset mid-fetch SHALL abandon the outstanding request; rom_ack during reset SHALL be ignored.
REQ-027 First fetch after reset SHALL be address 4'h0.

Structure
REQ-028 Opcode constants, BUBBLE and FSM state encoding SHALL live in shared package cpu4_pkg, used also by alu_ctrl.
REQ-029 Single flat module; no sub-module required; IR and pc inline.

Verification
REQ-030 Reset release, rom_ack every cycle, ROM[0..3]=8'h31,8'h52,8'h03,8'h74 -> rom_addr 0,1,2,3 on consecutive cycles; D_BUS shows same bytes one per cycle, d_valid=1 from 2nd ack onward.
REQ-031 ROM[2]=8'hF9, ack every cycle -> br_taken pulses with D_BUS=F9; byte from addr 3 dropped (one bubble); next rom_addr=9.
REQ-032 ROM[1]=8'hE5, cflag=1 -> br_taken=0, sequential fetch 2,3; rerun with cflag=0 -> br_taken=1, next rom_addr=5.
REQ-033 Taken F4 while addr 3 outstanding, rom_ack delayed 3 cycles -> rom_addr holds 3 until ack, data discarded, d_valid=0, then rom_addr=4.
REQ-034 Fetch from 4'hF without jump -> next rom_addr=0; reset asserted mid-request -> rom_req falls same cycle, first post-reset address 0.
